// File: rtl/verifica_senha_multi_if.sv
// Request/result bundle between keypad capture, the multi-slot password checker and lock control.
interface verifica_senha_multi_if #(
    parameter int IN_DIGITS = 20,
    parameter int PW_DIGITS = 12,
    parameter int NUM_PW    = 4
);
    localparam int IDX_W = (NUM_PW > 1) ? $clog2(NUM_PW) : 1;
    localparam int OFF_W = $clog2(IN_DIGITS);

    logic                          valid_in;
    logic                          abort;
    logic [4*IN_DIGITS-1:0]        senha_teste;
    logic [4*PW_DIGITS*NUM_PW-1:0] senha_real;
    logic [NUM_PW-1:0]             pw_en;
    logic                          busy;
    logic                          done;
    logic                          senha_ok;
    logic [IDX_W-1:0]              match_idx;
    logic [OFF_W-1:0]              match_off;

    modport master (
        output valid_in, abort, senha_teste, senha_real, pw_en,
        input  busy, done, senha_ok, match_idx, match_off
    );

    modport slave (
        input  valid_in, abort, senha_teste, senha_real, pw_en,
        output busy, done, senha_ok, match_idx, match_off
    );
endinterface

// File: rtl/verifica_senha_multi.sv
// Multi-slot password checker: snapshots the entered digits and slides every enabled
// stored password over them, lowest slot first, then lowest offset first.
module verifica_senha_multi #(
    parameter int IN_DIGITS = 20,
    parameter int PW_DIGITS = 12,
    parameter int MIN_LEN   = 4,
    parameter int NUM_PW    = 4
) (
    input logic                   clk,
    input logic                   rst,
    verifica_senha_multi_if.slave bus
);
    localparam int IDX_W = (NUM_PW > 1) ? $clog2(NUM_PW) : 1;
    localparam int OFF_W = $clog2(IN_DIGITS);
    localparam int LEN_W = $clog2(PW_DIGITS + 1);
    localparam int PW_W  = 4 * PW_DIGITS;

    typedef enum logic [1:0] {S_IDLE, S_LEN, S_SCAN, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       slot_q, slot_d;
    logic [OFF_W-1:0]       off_q, off_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   ok_q, ok_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [OFF_W-1:0]       moff_q, moff_d;
    logic                   snap;

    logic [4*IN_DIGITS-1:0] teste_q;
    logic [PW_W*NUM_PW-1:0] real_q;
    logic [NUM_PW-1:0]      en_q;

    logic [PW_W-1:0]        cur_pw;
    logic                   cur_en;
    logic [LEN_W-1:0]       cur_len;
    logic [PW_W-1:0]        win;
    logic                   cur_valid, cur_match, last_slot, last_off;

    // Slot selection via constant-index mux keeps every select statically bounded.
    always_comb begin
        cur_pw = '1;
        cur_en = 1'b0;
        for (int s = 0; s < NUM_PW; s++) begin
            if (slot_q == IDX_W'(s)) begin
                cur_pw = real_q[s*PW_W +: PW_W];
                cur_en = en_q[s];
            end
        end
    end

    // Length = index of the first 4'hF; scanning downwards lets the lowest one win.
    always_comb begin
        cur_len = LEN_W'(PW_DIGITS);
        for (int i = PW_DIGITS - 1; i >= 0; i--) begin
            if (cur_pw[4*i +: 4] == 4'hF) cur_len = LEN_W'(i);
        end
    end

    // Window of the entered digits starting at the current offset; o+i is int-wide, so it never wraps.
    always_comb begin
        win       = '1;
        cur_match = 1'b1;
        for (int o = 0; o < IN_DIGITS; o++) begin
            if (off_q == OFF_W'(o)) begin
                for (int i = 0; i < PW_DIGITS; i++) begin
                    if (o + i < IN_DIGITS) win[4*i +: 4] = teste_q[4*(o+i) +: 4];
                end
            end
        end
        for (int i = 0; i < PW_DIGITS; i++) begin
            if (i < int'(len_q) && cur_pw[4*i +: 4] != win[4*i +: 4]) cur_match = 1'b0;
        end
    end

    assign cur_valid = cur_en && (int'(cur_len) >= MIN_LEN) && (int'(cur_len) <= IN_DIGITS);
    assign last_slot = (int'(slot_q) == NUM_PW - 1);
    assign last_off  = (int'(off_q) == IN_DIGITS - int'(len_q));

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        off_d   = off_q;
        len_d   = len_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ok_d    = ok_q;
        idx_d   = idx_q;
        moff_d  = moff_q;
        snap    = 1'b0;
        if (bus.abort) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.valid_in) begin
                    state_d = S_LEN;
                    slot_d  = '0;
                    off_d   = '0;
                    busy_d  = 1'b1;
                    ok_d    = 1'b0;
                    idx_d   = '0;
                    moff_d  = '0;
                    snap    = 1'b1;
                end
                S_LEN: begin
                    if (cur_valid) begin
                        state_d = S_SCAN;
                        off_d   = '0;
                        len_d   = cur_len;
                    end else if (last_slot) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        slot_d  = slot_q + 1'b1;
                    end
                end
                S_SCAN: begin
                    if (cur_match) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        ok_d    = 1'b1;
                        idx_d   = slot_q;
                        moff_d  = off_q;
                    end else if (last_off && last_slot) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else if (last_off) begin
                        state_d = S_LEN;
                        slot_d  = slot_q + 1'b1;
                    end else begin
                        off_d   = off_q + 1'b1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
            off_q   <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            idx_q   <= '0;
            moff_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            off_q   <= off_d;
            len_q   <= len_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            idx_q   <= idx_d;
            moff_q  <= moff_d;
        end
    end

    // NOTE: the snapshot is plain flops, not a memory, so it is cleared on reset like any register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            teste_q <= '0;
            real_q  <= '0;
            en_q    <= '0;
        end else if (snap) begin
            teste_q <= bus.senha_teste;
            real_q  <= bus.senha_real;
            en_q    <= bus.pw_en;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.senha_ok  = ok_q;
    assign bus.match_idx = idx_q;
    assign bus.match_off = moff_q;
endmodule

// File: tb/tb_verifica_senha_multi.sv
// Scoreboard bench for verifica_senha_multi: directed requests push expected results,
// a negedge monitor pops and compares them whenever done is seen.
module tb_verifica_senha_multi;
    localparam int IN   = 20;
    localparam int PW   = 12;
    localparam int NP   = 4;
    localparam int MINL = 4;

    typedef struct {
        logic ok;
        int   idx;
        int   off;
        int   lat;
        int   start;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    logic [3:0] t_d[IN];
    logic [3:0] r_d[NP][PW];

    verifica_senha_multi_if #(.IN_DIGITS(IN), .PW_DIGITS(PW), .NUM_PW(NP)) bus ();

    verifica_senha_multi #(.IN_DIGITS(IN), .PW_DIGITS(PW), .MIN_LEN(MINL), .NUM_PW(NP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must correspond to the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && bus.done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("senha_ok", 32'(bus.senha_ok), 32'(mon_e.ok));
                check("match_idx", 32'(bus.match_idx), mon_e.idx);
                check("match_off", 32'(bus.match_off), mon_e.off);
                check("latency", cyc - mon_e.start, mon_e.lat);
                check("busy_at_done", 32'(bus.busy), 32'd0);
            end
        end
    end

    task automatic clear_all();
        for (int i = 0; i < IN; i++) t_d[i] = 4'hF;
        for (int s = 0; s < NP; s++)
            for (int i = 0; i < PW; i++) r_d[s][i] = 4'hF;
    endtask

    task automatic put_t(input int pos, input string str);
        for (int i = 0; i < str.len(); i++) t_d[pos+i] = 4'(str[i] - 8'h30);
    endtask

    task automatic set_slot(input int s, input string str);
        for (int i = 0; i < PW; i++) r_d[s][i] = 4'hF;
        for (int i = 0; i < str.len(); i++) r_d[s][i] = 4'(str[i] - 8'h30);
    endtask

    task automatic apply(input logic [NP-1:0] en);
        for (int i = 0; i < IN; i++) bus.senha_teste[4*i +: 4] = t_d[i];
        for (int s = 0; s < NP; s++)
            for (int i = 0; i < PW; i++) bus.senha_real[4*(PW*s+i) +: 4] = r_d[s][i];
        bus.pw_en = en;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input bit push, input logic ok, input int idx, input int off, input int lat);
        exp_t e;
        bus.valid_in = 1'b1;
        @(negedge clk);
        bus.valid_in = 1'b0;
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        check("ok_cleared", 32'(bus.senha_ok), 32'd0);
        check("idx_cleared", 32'(bus.match_idx), 32'd0);
        check("off_cleared", 32'(bus.match_off), 32'd0);
        if (push) begin
            e.ok = ok; e.idx = idx; e.off = off; e.lat = lat; e.start = cyc;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_timeout", sb_q.size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_ok"}, 32'(bus.senha_ok), 32'd0);
        check({tag, "_idx"}, 32'(bus.match_idx), 32'd0);
        check({tag, "_off"}, 32'(bus.match_off), 32'd0);
    endtask

    task automatic cfg_basic();
        clear_all();
        set_slot(0, "1234");
        put_t(0, "1234");
        apply(4'b0001);
    endtask

    task automatic cfg_slot2();
        clear_all();
        set_slot(0, "1111");
        set_slot(1, "2222");
        set_slot(2, "987654");
        set_slot(3, "5555");
        put_t(14, "987654");
        apply(4'b1111);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.valid_in = 1'b0;
        bus.abort = 1'b0;
        bus.senha_teste = '1;
        bus.senha_real = '1;
        bus.pw_en = '0;
        #1 rst = 1'b0;
        #2 check_outputs_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Basic match in slot 0 at offset 0.
        cfg_basic();
        issue(1, 1'b1, 0, 0, 2);
        wait_drain();

        // Priority: slot 1 beats slot 3, offset 3 beats offset 10; slot 0 disabled costs one cycle.
        clear_all();
        set_slot(1, "5678");
        set_slot(3, "5678");
        put_t(3, "5678");
        put_t(10, "5678");
        apply(4'b1010);
        issue(1, 1'b1, 1, 3, 6);
        wait_drain();

        // Match at the last legal offset IN-len = 16.
        clear_all();
        set_slot(0, "4321");
        put_t(16, "4321");
        apply(4'b0001);
        issue(1, 1'b1, 0, 16, 18);
        wait_drain();

        // Full-length slot (no 4'hF), last offset 8.
        clear_all();
        set_slot(0, "123456789012");
        put_t(8, "123456789012");
        apply(4'b0001);
        issue(1, 1'b1, 0, 8, 10);
        wait_drain();

        // Slot 2 match at offset 14 after two full failing scans.
        cfg_slot2();
        issue(1, 1'b1, 2, 14, 52);
        wait_drain();

        // No slot present: four full scans, then all slots disabled.
        cfg_slot2();
        set_slot(2, "3333");
        apply(4'b1111);
        issue(1, 1'b0, 0, 0, 72);
        wait_drain();
        apply(4'b0000);
        issue(1, 1'b0, 0, 0, 4);
        wait_drain();

        // Short slot and all-F slot are skipped even though "123" is present.
        clear_all();
        set_slot(0, "123");
        set_slot(2, "9999");
        put_t(0, "123");
        apply(4'b0111);
        issue(1, 1'b0, 0, 0, 21);
        wait_drain();

        // Snapshot: inputs changed and valid_in pulsed while busy must not matter.
        cfg_slot2();
        issue(1, 1'b1, 2, 14, 52);
        cfg_basic();
        repeat (8) @(negedge clk);
        bus.valid_in = 1'b1;
        @(negedge clk);
        bus.valid_in = 1'b0;
        check("busy_after_valid_while_busy", 32'(bus.busy), 32'd1);
        wait_drain();

        // valid_in during the done cycle is ignored; the next cycle accepts.
        cfg_basic();
        issue(1, 1'b1, 0, 0, 2);
        @(negedge clk);
        @(negedge clk);
        check("done_visible", 32'(bus.done), 32'd1);
        bus.valid_in = 1'b1;
        @(negedge clk);
        bus.valid_in = 1'b0;
        check("valid_at_done_ignored", 32'(bus.busy), 32'd0);
        issue(1, 1'b1, 0, 0, 2);
        wait_drain();

        // Abort while scanning offset 5: no done pulse may follow.
        clear_all();
        set_slot(0, "1234");
        apply(4'b0001);
        issue(0, 1'b0, 0, 0, 0);
        repeat (6) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_ok", 32'(bus.senha_ok), 32'd0);
        repeat (25) @(negedge clk);
        check("abort_idle_busy", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of a scan.
        cfg_slot2();
        issue(1, 1'b1, 2, 14, 52);
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_outputs_zero("midreset");
        sb_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        cfg_basic();
        issue(1, 1'b1, 0, 0, 2);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/verifica_senha_multi.md
Name: verifica_senha_multi

Overview:
- Parametrised successor of the single-password checker in the lock datapath.
- Snapshots one entered digit sequence and searches it, as a sliding window, for any of NUM_PW stored passwords, each gated by an enable bit.
- Reports pass/fail, which slot matched and at what offset; sits between keypad capture and the lock control FSM.

Parameters:
- IN_DIGITS, 20: digits in the entered sequence.
- PW_DIGITS, 12: maximum digits per stored password.
- MIN_LEN, 4: minimum valid password length.
- NUM_PW, 4: number of stored password slots.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- valid_in  in  1  request pulse; accepted only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE, no done
- senha_teste  in  4*IN_DIGITS  entered digits; digit i at [4i+3:4i]; 4'hF = empty
- senha_real  in  4*PW_DIGITS*NUM_PW  slot s occupies [4*PW_DIGITS*(s+1)-1 : 4*PW_DIGITS*s], same digit packing
- pw_en  in  NUM_PW  per-slot enable
- busy  out  1  high from acceptance until done
- done  out  1  one-cycle completion pulse
- senha_ok  out  1  1 = some slot matched
- match_idx  out  max(1,$clog2(NUM_PW))  matched slot
- match_off  out  $clog2(IN_DIGITS)  matched offset in senha_teste

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; snapshot registers 0. All outputs are registered.
- Snapshot: the edge that accepts valid_in in IDLE captures senha_teste, senha_real and pw_en. Later input changes do not affect the operation in progress. valid_in is ignored while busy.
- Result hold: at acceptance, senha_ok, match_idx and match_off clear to 0. They are updated at DONE and hold until the next acceptance.
- Length of a slot: index of its first 4'hF digit, or PW_DIGITS if it has none. Digits after the first 4'hF are ignored.
- Invalid slot: pw_en=0, or len<MIN_LEN (this includes an all-F slot). The slot is skipped.
- States:
  - IDLE: on valid_in, go to LEN; slot=0; busy<=1.
  - LEN (1 cycle per slot): compute len. If the slot is valid, go to SCAN with off=0. Otherwise go to the next slot's LEN, or to DONE after the last slot.
  - SCAN (1 cycle per offset): match if real[i]==teste[off+i] for all i<len. On a match, go to DONE, record slot/off, and set senha_ok. Else if off==IN_DIGITS-len, go to the next slot's LEN or to DONE. Else off++.
  - DONE (1 cycle): done=1, busy<=0, then IDLE.
- Offsets: never exceed IN_DIGITS-len. If len>IN_DIGITS, the slot gets zero SCAN cycles and is treated as invalid.
- Priority: lowest slot index first; within a slot, lowest offset first.
- Arithmetic: offset plus index is computed at least 1 bit wider than $clog2(IN_DIGITS), so there is no wrap-around.
- Latency (edges after the accepting edge E0, to the edge that enters DONE):
  - Define K_j = IN_DIGITS-len_j+1 for a valid slot, else 0.
  - Match in slot s at offset o: T = sum_{j<s}(1+K_j) + 1 + (o+1).
  - No match: T = sum_{all j}(1+K_j).
- Abort: highest priority over everything except reset. It forces IDLE; busy<=0; done is not pulsed; result outputs keep their cleared values.
- valid_in in the same cycle as done is ignored. Acceptance is possible from the following cycle.
- Reset mid-operation: outputs are immediately 0 and the FSM is in IDLE.

Test Plan:
- Default parameters; slot0="1234" (len 4); teste digits 0..3 = 1,2,3,4, rest F; pw_en=4'b0001 -> done at T=2, senha_ok=1, match_idx=0, match_off=0.
- Slot2="987654" (len 6); teste has 9,8,7,6,5,4 at digits 14..19; slots 0,1 len 4, all slots enabled, no earlier match -> senha_ok=1, match_idx=2, match_off=14, T=18+18+1+15=52.
- All four slots len 4, none present in teste -> done at T=72, senha_ok=0. Repeat with pw_en=4'b0000 -> T=4, senha_ok=0.
- Slot0 len 3 ("123F…") plus an all-F slot, both enabled, "123" present in teste -> both skipped (1 cycle each), no match from them.
- Snapshot and valid_in handling:
  - Change senha_teste during busy -> result uses the captured value.
  - Assert valid_in while busy -> ignored.
  - Assert valid_in again in the cycle after done -> accepted.
- Abort at SCAN off=5 -> next cycle IDLE, busy=0, no done pulse.
- Drive rst=0 mid-SCAN -> all outputs 0 asynchronously.
